// File: rtl/commit_rat_pkg.sv
// Shared commit/rename definitions: micro-op layout,
// tag and register widths, and the constant-tag value.
package commit_rat_pkg;

    localparam int UOP_W  = 23;
    localparam int TAG_W  = 7;
    localparam int PTAG_W = 6;
    localparam int NM_W   = 5;
    localparam int NM_CNT = 32;

    localparam logic [TAG_W-1:0] TAG_CONST = 7'h40;

    typedef struct packed {
        logic [NM_W-1:0]  nm_dst;
        logic [TAG_W-1:0] tag_dst;
        logic [6:0]       sqn;
        logic             is_branch;
        logic             rsvd;
        logic             compressed;
        logic             valid;
    } com_uop_t;

    function automatic logic is_phys(input logic [TAG_W-1:0] t);
        return !t[TAG_W-1];
    endfunction

endpackage

// File: rtl/free_tag_fifo.sv
// Free physical-tag FIFO: up to WIDTH pushes per cycle
// in port order, two in-order pop lanes, sticky overflow.
import commit_rat_pkg::*;

module free_tag_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             push_valid,
    input  logic [WIDTH-1:0][PTAG_W-1:0] push_tag,
    input  logic [1:0]                   ready,
    output logic [1:0][PTAG_W-1:0]       tag,
    output logic [1:0]                   valid,
    output logic [CNT_W-1:0]             count,
    output logic                         overflow
);

    logic [PTAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;

    logic              pop0;
    logic              pop1;
    logic [CNT_W-1:0]  pop_cnt;
    logic [CNT_W-1:0]  room;
    logic [CNT_W-1:0]  push_cnt;
    logic              drop;
    logic [DEPTH-1:0]  wr_en;
    logic [PTAG_W-1:0] wr_data [DEPTH];
    logic [PTR_W-1:0]  slot;

    assign count    = count_q;
    assign overflow = ovf_q;
    assign valid    = {count_q > CNT_W'(1), count_q != '0};
    assign tag[0]   = mem[rptr];
    assign tag[1]   = mem[rptr + PTR_W'(1)];

    assign pop0    = valid[0] & ready[0];
    assign pop1    = pop0 & valid[1] & ready[1];
    assign pop_cnt = CNT_W'(pop0) + CNT_W'(pop1);
    assign room    = CNT_W'(DEPTH) - count_q + pop_cnt;

    // Pack accepted pushes into consecutive slots; flag any excess.
    always_comb begin
        push_cnt = '0;
        drop     = 1'b0;
        wr_en    = '0;
        slot     = '0;
        for (int s = 0; s < DEPTH; s++) wr_data[s] = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (push_valid[i]) begin
                if (push_cnt < room) begin
                    slot          = wptr + push_cnt[PTR_W-1:0];
                    wr_en[slot]   = 1'b1;
                    wr_data[slot] = push_tag[i];
                    push_cnt      = push_cnt + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Pointer, occupancy and sticky-overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr    <= '0;
            wptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr    <= rptr + pop_cnt[PTR_W-1:0];
            wptr    <= wptr + push_cnt[PTR_W-1:0];
            count_q <= count_q + push_cnt - pop_cnt;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (!rst && wr_en[s]) mem[s] <= wr_data[s];
        end
    end

endmodule

// File: rtl/commit_rat.sv
// Committed register alias table: retires up to WIDTH
// mappings per cycle and recycles displaced physical tags.
import commit_rat_pkg::*;

module commit_rat #(
    parameter int WIDTH      = 4,
    parameter int FREE_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH*UOP_W-1:0] IN_comUOp,
    input  logic                   IN_mispredFlush,
    output logic [2*PTAG_W-1:0]    OUT_freeTag,
    output logic [1:0]             OUT_freeValid,
    input  logic [1:0]             IN_freeReady,
    input  logic [NM_W-1:0]        IN_lookupNm,
    output logic [TAG_W-1:0]       OUT_lookupTag,
    output logic                   OUT_stall,
    output logic                   OUT_overflow
);

    localparam int CNT_W    = $clog2(FREE_DEPTH) + 1;
    localparam int STALL_AT = FREE_DEPTH - 2 * WIDTH;

    logic [TAG_W-1:0]             map_q [NM_CNT];
    logic [TAG_W-1:0]             map_d [NM_CNT];
    com_uop_t                     uop [WIDTH];
    logic [TAG_W-1:0]             old;
    logic [WIDTH-1:0]             push_valid;
    logic [WIDTH-1:0][PTAG_W-1:0] push_tag;
    logic [1:0][PTAG_W-1:0]       fifo_tag;
    logic [CNT_W-1:0]             count;
    logic                         unused_fields;

    // Split the flat port bus into per-port micro-ops.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            uop[i] = com_uop_t'(IN_comUOp[i*UOP_W +: UOP_W]);
        end
    end

    // Ordering metadata plays no part in committed state.
    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            unused_fields = unused_fields ^ (^{uop[i].sqn,
                uop[i].is_branch, uop[i].rsvd, uop[i].compressed});
        end
    end

    // Apply commits in port order so later ports see earlier writes.
    always_comb begin
        map_d      = map_q;
        push_valid = '0;
        push_tag   = '0;
        old        = TAG_CONST;
        for (int i = 0; i < WIDTH; i++) begin
            if (uop[i].valid && !IN_mispredFlush &&
                uop[i].nm_dst != '0) begin
                old                  = map_d[uop[i].nm_dst];
                push_valid[i]        = is_phys(old);
                push_tag[i]          = old[PTAG_W-1:0];
                map_d[uop[i].nm_dst] = uop[i].tag_dst;
            end
        end
    end

    // Committed map register.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NM_CNT; n++) begin
            if (rst) map_q[n] <= TAG_CONST;
            else     map_q[n] <= map_d[n];
        end
    end

    assign OUT_lookupTag = (IN_lookupNm == '0) ? TAG_CONST
                                               : map_q[IN_lookupNm];
    assign OUT_freeTag   = fifo_tag;
    assign OUT_stall     = count > CNT_W'(STALL_AT);

    free_tag_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FREE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_tag   (push_tag),
        .ready      (IN_freeReady),
        .tag        (fifo_tag),
        .valid      (OUT_freeValid),
        .count      (count),
        .overflow   (OUT_overflow)
    );

endmodule

// File: tb/tb_commit_rat.sv
// Randomized and directed bench for commit_rat against
// a map-array / tag-queue reference model.
module tb_commit_rat;

    localparam int W = 4;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W*23-1:0] comuop = '0;
    logic          flush = 1'b0;
    logic [11:0]   free_tag;
    logic [1:0]    free_valid;
    logic [1:0]    ready = 2'b00;
    logic [4:0]    lnm = '0;
    logic [6:0]    ltag;
    logic          stall;
    logic          ovf;

    commit_rat #(.WIDTH(W), .FREE_DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_comUOp       (comuop),
        .IN_mispredFlush (flush),
        .OUT_freeTag     (free_tag),
        .OUT_freeValid   (free_valid),
        .IN_freeReady    (ready),
        .IN_lookupNm     (lnm),
        .OUT_lookupTag   (ltag),
        .OUT_stall       (stall),
        .OUT_overflow    (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [6:0] m [32];
    logic [5:0] q [$];
    logic       m_ovf;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", name, obs, exp);
    endtask

    function automatic logic [22:0] uop(input logic v, input logic [4:0] nm,
                                        input logic [6:0] tag);
        logic [6:0] sqn;
        logic [2:0] junk;
        sqn  = 7'($urandom);
        junk = 3'($urandom);
        return {nm, tag, sqn, junk, v};
    endfunction

    function automatic logic [6:0] rtag();
        if ($urandom_range(0, 3) == 0) return {1'b1, 6'($urandom)};
        return {1'b0, 6'($urandom)};
    endfunction

    // Ports 0..n-1 rewrite nm 1..n with physical tags base+i.
    task automatic push_n(input int n, input logic [5:0] base);
        for (int i = 0; i < W; i++) begin
            if (i < n)
                comuop[i*23 +: 23] = uop(1'b1, 5'(i + 1), {1'b0, 6'(base + 6'(i))});
            else
                comuop[i*23 +: 23] = uop(1'b0, 5'($urandom), rtag());
        end
    endtask

    task automatic step();
        logic [5:0] pl [$];
        logic [22:0] u;
        logic [6:0] old;
        int npop;
        if (rst) begin
            for (int n = 0; n < 32; n++) m[n] = 7'h40;
            q.delete();
            m_ovf = 1'b0;
        end else begin
            npop = 0;
            if (q.size() > 0 && ready[0]) begin
                npop = 1;
                if (q.size() > 1 && ready[1]) npop = 2;
            end
            if (!flush) begin
                for (int i = 0; i < W; i++) begin
                    u = comuop[i*23 +: 23];
                    if (u[0] && u[22:18] != 5'd0) begin
                        old = m[u[22:18]];
                        if (!old[6]) pl.push_back(old[5:0]);
                        m[u[22:18]] = u[17:11];
                    end
                end
            end
            repeat (npop) void'(q.pop_front());
            foreach (pl[k]) begin
                if (q.size() < D) q.push_back(pl[k]);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("valid", 32'(free_valid), 32'({q.size() > 1, q.size() > 0}));
        if (q.size() > 0) check("lane0", 32'(free_tag[5:0]), 32'(q[0]));
        if (q.size() > 1) check("lane1", 32'(free_tag[11:6]), 32'(q[1]));
        check("stall", 32'(stall), 32'(q.size() > 8));
        check("overflow", 32'(ovf), 32'(m_ovf));
        lnm = 5'($urandom);
        #1;
        check("lookup", 32'(ltag), 32'(m[lnm]));
    endtask

    task automatic lookup_all();
        for (int n = 0; n < 32; n++) begin
            lnm = 5'(n);
            #1;
            check("map", 32'(ltag), 32'(m[n]));
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step();
        lookup_all();
        check("rst_valid", 32'(free_valid), 32'(0));
        rst = 1'b0;

        // first commit, then displace it
        comuop = '0;
        comuop[22:0] = uop(1'b1, 5'd5, 7'h12);
        step();
        lnm = 5'd5;
        #1;
        check("c1_map", 32'(ltag), 32'h12);
        check("c1_nopush", 32'(free_valid), 32'(0));
        comuop[22:0] = uop(1'b1, 5'd5, 7'h13);
        step();
        check("c2_free", 32'(free_tag[5:0]), 32'h12);
        check("c2_valid", 32'(free_valid), 32'(1));

        // same-nm chain across three ports
        ready = 2'b11;
        comuop = '0;
        comuop[22:0] = uop(1'b1, 5'd3, 7'h1F);
        step();
        ready = 2'b00;
        comuop[22:0]  = uop(1'b1, 5'd3, 7'h20);
        comuop[45:23] = uop(1'b1, 5'd3, 7'h21);
        comuop[68:46] = uop(1'b1, 5'd3, 7'h22);
        comuop[91:69] = uop(1'b0, 5'd3, 7'h05);
        step();
        check("chain_l0", 32'(free_tag[5:0]), 32'h1F);
        check("chain_l1", 32'(free_tag[11:6]), 32'h20);
        lnm = 5'd3;
        #1;
        check("chain_map", 32'(ltag), 32'h22);
        ready = 2'b11;
        comuop = '0;
        step();
        check("chain_l0b", 32'(free_tag[5:0]), 32'h21);

        // flush, nm 0 and constant old tag produce no pushes
        ready = 2'b00;
        flush = 1'b1;
        comuop[22:0]  = uop(1'b1, 5'd3, 7'h01);
        comuop[45:23] = uop(1'b1, 5'd5, 7'h02);
        comuop[68:46] = uop(1'b1, 5'd7, 7'h03);
        comuop[91:69] = uop(1'b1, 5'd9, 7'h04);
        step();
        flush = 1'b0;
        lnm = 5'd3;
        #1;
        check("flush_map", 32'(ltag), 32'h22);
        check("flush_valid", 32'(free_valid), 32'(1));
        comuop = '0;
        comuop[22:0] = uop(1'b1, 5'd0, 7'h05);
        step();
        lnm = 5'd0;
        #1;
        check("nm0_map", 32'(ltag), 32'h40);
        comuop[22:0] = uop(1'b1, 5'd9, 7'h30);
        step();
        check("const_old", 32'(free_valid), 32'(1));
        comuop = '0;
        ready = 2'b11;
        repeat (2) step();

        // fill, stall threshold, full with pops, overflow
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready = 2'b00;
        push_n(4, 6'h00);
        step();
        push_n(4, 6'h04);
        step();
        push_n(4, 6'h08);
        step();
        check("stall8", 32'(stall), 32'(0));
        push_n(1, 6'h0C);
        step();
        check("stall9", 32'(stall), 32'(1));
        push_n(3, 6'h10);
        step();
        push_n(2, 6'h14);
        step();
        ready = 2'b11;
        push_n(4, 6'h18);
        step();
        check("full_noovf", 32'(ovf), 32'(0));
        check("full_valid", 32'(free_valid), 32'(3));
        ready = 2'b00;
        push_n(4, 6'h1C);
        step();
        check("ovf_set", 32'(ovf), 32'(1));
        comuop = '0;
        ready = 2'b11;
        repeat (8) step();
        check("drained", 32'(free_valid), 32'(0));
        check("ovf_held", 32'(ovf), 32'(1));

        // pointer wrap with single-lane readiness
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_n(4, 6'h20);
        step();
        ready = 2'b01;
        for (int c = 0; c < 40; c++) begin
            push_n($urandom_range(0, 2), 6'($urandom));
            step();
        end
        ready = 2'b10;
        for (int c = 0; c < 40; c++) begin
            push_n((c % 4 == 0) ? 1 : 0, 6'($urandom));
            step();
        end
        comuop = '0;
        ready = 2'b11;
        repeat (10) step();

        // random traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < W; i++)
                comuop[i*23 +: 23] = uop($urandom_range(0, 3) != 0,
                                         5'($urandom), rtag());
            flush = ($urandom_range(0, 7) == 0);
            ready = 2'($urandom);
            step();
        end
        flush = 1'b0;

        // reset during a 4-port commit
        push_n(4, 6'h2A);
        ready = 2'b11;
        rst = 1'b1;
        step();
        rst = 1'b0;
        comuop = '0;
        check("rst2_valid", 32'(free_valid), 32'(0));
        check("rst2_stall", 32'(stall), 32'(0));
        check("rst2_ovf", 32'(ovf), 32'(0));
        for (int n = 0; n < 32; n++) begin
            lnm = 5'(n);
            #1;
            check("rst2_map", 32'(ltag), 32'h40);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/commit_rat.md
COMMIT_RAT -- requirements
Module: commit_rat

Interface
REQ-001 SHALL have parameter WIDTH, default 4; number of commit ports.
REQ-002 SHALL have parameter FREE_DEPTH, default 16; free-tag FIFO entries (power of two, >= 2*WIDTH).
REQ-003 SHALL have ports clk input 1 (clock) and rst input 1 (reset, synchronous, active-high), listed first.
REQ-004 SHALL have IN_comUOp input WIDTH*23 for commit ports. Per port: [0] valid, [1] compressed, [3] isBranch, [10:4] sqN, [17:11] tagDst, [22:18] nmDst. Bit [2] is ignored.
REQ-005 SHALL have IN_mispredFlush input 1; while high, the ports carry replay traffic, not commits.
REQ-006 SHALL have OUT_freeTag output 2*6, the two oldest FIFO entries, lane 0 = oldest.
REQ-007 SHALL have OUT_freeValid output 2; lane k is valid when count > k.
REQ-008 SHALL have IN_freeReady input 2, consumer pop request per lane.
REQ-009 SHALL have IN_lookupNm input 5 and OUT_lookupTag output 7, a committed-map read port.
REQ-010 SHALL have OUT_stall output 1 (commit backpressure) and OUT_overflow output 1 (sticky error).

Function
REQ-011 SHALL hold a committed map of 32 x 7-bit tags; tag bit6=1 denotes a non-physical (constant/immediate) tag.
REQ-012 Port i commits when valid=1, IN_mispredFlush=0 and nmDst!=0. Otherwise the port has no effect.
REQ-013 For each committing port, old = current mapping of nmDst, including same-cycle writes from lower-index ports (in-order forwarding). The mapping becomes tagDst at the next edge.
REQ-014 Multiple ports with the same nmDst in one cycle: the final map = tagDst of the highest-index port, and every displaced tag is freed in port order.
REQ-015 A displaced old tag with bit6=0 SHALL push old[5:0] into the FIFO. Bit6=1 pushes nothing.
REQ-016 Up to WIDTH pushes per cycle, in ascending port order, at consecutive write-pointer slots; pointers wrap modulo FREE_DEPTH.
REQ-017 Pop: lane 0 pops if freeValid[0]&freeReady[0]; lane 1 pops only if lane 0 pops and freeValid[1]&freeReady[1]. Pop count is 0..2.
REQ-018 Push and pop in the same cycle are both honoured. next count = count + pushes - pops, and pops see only pre-edge contents.
REQ-019 OUT_freeTag/OUT_freeValid SHALL be driven from FIFO state combinationally; latency from push edge to visibility is 1 cycle.
REQ-020 OUT_stall = (count > FREE_DEPTH - 2*WIDTH), combinational from registered count. This gives one cycle of slack for a registered commit source.
REQ-021 On a push exceeding capacity, excess pushes SHALL be dropped in port order and OUT_overflow SHALL be set and held until reset.
REQ-022 OUT_lookupTag = map[IN_lookupNm], combinational from registered state, without same-cycle commit forwarding. nm 0 returns 7'h40.
REQ-023 IN_mispredFlush SHALL NOT affect the FIFO or pops.
REQ-024 Fields compressed, isBranch and sqN SHALL be ignored by state updates.

Reset
REQ-025 On rst: every map entry = 7'h40, FIFO empty (pointers and count 0), OUT_overflow=0, OUT_freeValid=0, OUT_stall=0.
REQ-026 rst SHALL take priority over same-cycle commits and pops. Mid-operation reset discards all pending pushes.

Structure
REQ-027 The comUOp field layout, the 7'h40 constant tag, and the tag/register widths SHALL live in the shared package used by the commit and rename stages.
REQ-028 The FIFO SHALL be a sub-module free_tag_fifo (multi-push WIDTH, dual-pop) instantiated once. The map plus port-forwarding logic lives in commit_rat.

Verification
REQ-029 Reset, then commit port0 nm=5 tag=7'h12 -> lookup nm5 = 7'h12 next cycle, no push. Then commit nm=5 tag=7'h13 -> free FIFO lane0 = 6'h12 one cycle later.
REQ-030 Same cycle: ports 0,1,2 write nm=3 with tags 0x20, 0x21, 0x22 after map[3]=0x1F -> pushes 0x1F, 0x20, 0x21 in order, and map[3]=0x22.
REQ-031 Commit with IN_mispredFlush=1 and valid ports -> map unchanged and no pushes. Commit with nmDst=0 or old tag 7'h40 -> no push.
REQ-032 Fill to 12 entries -> OUT_stall=1 at count 9+. Four pushes with both lanes popping at count 14 -> count 16, no overflow. One more 4-push with no pop -> OUT_overflow=1 and count stays 16.
REQ-033 Pointer wrap: 40 push/pop cycles with freeReady=2'b01 then 2'b10 -> FIFO order preserved; lane 1 never pops without lane 0.
REQ-034 Assert rst during a 4-port commit -> all outputs at reset values next cycle and the map is all 7'h40.
